// File: rtl/hs32_mem_resp_pkg.sv
// Shared constants for the hs32 execute unit and the memory responder FSM.
// The responder's address-fault rule lives here so every user applies the same test.
package hs32_mem_resp_pkg;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int WAIT_CNT_W = 4;
    localparam int MAX_WAIT   = 15;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACC  = 2'd2,
        S_RESP = 2'd3
    } mem_state_t;

    // A word access faults when it is misaligned or reaches past the 2^aw-word array.
    function automatic logic addr_fault(input logic [31:0] a, input int aw);
        return (a[1:0] != 2'b00) || ((a >> (aw + 2)) != 32'd0);
    endfunction

endpackage

// File: rtl/hs32_mem_array.sv
// 2^AW x 32-bit single-port synchronous RAM with a registered read port.
// There is no reset, so the contents survive reset and the array maps onto block RAM.
module hs32_mem_array #(
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];

    // The read register only moves on an enabled read, so it keeps the last read word.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/hs32_mem_resp.sv
// Wait-state memory responder for the hs32 execute unit: IDLE -> WAIT -> ACC -> RESP.
// Define HS32_MEM_RESP_ERR_EN to flag and suppress misaligned or out-of-range accesses.
module hs32_mem_resp
    import hs32_mem_resp_pkg::*;
#(
    parameter int AW   = 10,
    parameter int WAIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] dtw,
    output logic [31:0] dtr,
    output logic        rdy,
    output logic        err,
    output logic        busy
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT);

    mem_state_t            state;
    mem_state_t            state_nxt;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic [31:0]           addr_q;
    logic [31:0]           dtw_q;
    logic                  rw_q;
    logic                  capture;
    logic                  arr_en;
    logic                  arr_we;
    logic                  fault;
    logic                  dtr_zero;
    logic [31:0]           arr_rdata;
    logic [AW-1:0]         word_idx;

    assign word_idx = addr_q[AW+1:2];

`ifdef HS32_MEM_RESP_ERR_EN
    assign fault = addr_fault(addr_q, AW);
`else
    // Without fault checking the byte-offset and upper bits simply alias.
    logic unused_addr_bits;
    assign fault            = 1'b0;
    assign unused_addr_bits = ^{addr_q[1:0], addr_q[31:AW+2]};
`endif

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        arr_en    = 1'b0;
        arr_we    = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    capture   = 1'b1;
                    state_nxt = (WAIT == 0) ? S_ACC : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wait_cnt <= 4'd1) begin
                    state_nxt = S_ACC;
                end
            end
            S_ACC: begin
                arr_en    = !fault;
                arr_we    = (rw_q == RW_WRITE);
                state_nxt = S_RESP;
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // dtr_zero masks the RAM read register after reset and after a faulting read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            addr_q   <= '0;
            dtw_q    <= '0;
            rw_q     <= RW_READ;
            rdy      <= 1'b0;
            err      <= 1'b0;
            dtr_zero <= 1'b1;
        end else begin
            state <= state_nxt;
            if (capture) begin
                addr_q   <= addr;
                dtw_q    <= dtw;
                rw_q     <= rw;
                wait_cnt <= WAIT_LOAD;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            rdy <= (state == S_ACC);
            err <= (state == S_ACC) && fault;
            if ((state == S_ACC) && (rw_q == RW_READ)) begin
                dtr_zero <= fault;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign dtr  = dtr_zero ? 32'd0 : arr_rdata;

    hs32_mem_array #(
        .AW(AW)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (word_idx),
        .wdata (dtw_q),
        .rdata (arr_rdata)
    );

endmodule
